cypher_stream_sequencer: RTL and testbench
==========================================

Name: cypher_stream_sequencer

Overview:
- Sequences a 4-digit cypher match over a handshaked stream of 4-bit digits and counts complete cypher occurrences.
- Latches the 16-bit cypher at start and steps a digit index per accepted input.
- Runs until a stop request or a digit-count limit, then holds the result.
- Sits in front of the cypher-detection logic as the block that owns digit ordering, restart-on-mismatch and run/stop sequencing.

Parameters:
- SUM_W, 10, width of match counter `sum`; saturates at 2^SUM_W-1.
- MAX_DIGITS, 64, digits accepted per run before automatic DONE; legal range 1..65535.

Ports:
- clock, input, 1, single clock; all logic on the rising edge.
- reset, input, 1, synchronous active-low reset.
- fullcypher, input, 16, cypher; digit0 = [15:12], digit1 = [11:8], digit2 = [7:4], digit3 = [3:0].
- start, input, 1, begin run; sampled in IDLE or DONE only.
- stop, input, 1, end run; sampled in RUN only.
- digit_valid, input, 1, digit_in is valid.
- digit_in, input, 4, stream digit.
- digit_ready, output, 1, block accepts a digit this cycle.
- busy, output, 1, high in RUN.
- match_pulse, output, 1, one-cycle pulse per complete match.
- done, output, 1, high in DONE.
- sum, output, SUM_W, completed-match count for the current/last run.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; idx=0; cnt=0; cypher_q=0.
  - Outputs: sum=0, match_pulse=0, done=0, busy=0, digit_ready=0.
  - Reset overrides every other input and aborts a run mid-operation with no partial result kept.
- States: IDLE, RUN, DONE. digit_ready=busy=(state==RUN), combinational from state.
- IDLE/DONE + start=1:
  - Latch cypher_q=fullcypher; clear sum, idx and cnt; clear match_pulse; go RUN next cycle.
  - DONE with start=0 holds sum and done.
- Accept = digit_valid & digit_ready. Only accepts change idx, cnt and sum.
- On accept, compare digit_in with cypher_q digit[idx]:
  - Equal and idx<3: idx=idx+1.
  - Equal and idx==3: full match; sum=sum+1 (saturating, no wrap); match_pulse=1 next cycle; idx=0.
  - Not equal: idx = (digit_in==digit0) ? 1 : 0. This is a single-level restart, not full prefix matching.
- Timing:
  - match_pulse and sum are registered and update on the edge that accepts the 4th matching digit, so they are visible the following cycle.
  - match_pulse is high for exactly one cycle, even when matches land on consecutive accepts.
- cnt increments on every accept. An accept that makes cnt==MAX_DIGITS moves the FSM to DONE.
- stop=1 in RUN moves to DONE next cycle.
  - A digit accepted in the same cycle is fully processed first, including any match.
- start in RUN is ignored. stop in IDLE/DONE is ignored.
- fullcypher changes after start have no effect until the next start.
- Digits presented while not in RUN are not accepted and have no effect.

Optional Feature:
- Macro: CYPHER_OVERLAP_EN.
- Defined: after a full match, idx = (digit_in==digit0) ? 1 : 0. The final digit of a match may therefore start the next match.
- Undefined: after a full match idx=0 (non-overlapping count).
- All other behaviour is identical in both builds.

Test Plan:
- reset=0 for 2 cycles with start=1 and digit_valid=1 -> state IDLE; sum=0, done=0, busy=0, digit_ready=0.
- Cypher 0x1234, start, stream 1,2,3,4 -> one match_pulse the cycle after the 4th accept; sum=1; then stop -> done=1, sum=1 held.
- Cypher 0x1234, stream 1,1,2,3,4,5,1,2,3,4 -> sum=2 (restart rule recovers the repeated 1).
- Cypher 0x1211, stream 1,2,1,1,2,1,1 -> sum=1 without CYPHER_OVERLAP_EN; sum=2 with it.
- MAX_DIGITS=8, cypher 0x5555, eight 5s with digit_valid gaps -> sum=2, done asserts the cycle after the 8th accept; a 9th digit sees digit_ready=0; a new start clears sum to 0.
- SUM_W=2, cypher 0xAAAA, twenty As -> sum saturates at 3, 5 match_pulses. Separately, reset=0 mid-match after 1,2,3 of 0x1234, then a new run -> first 4 does not match.

Source files
------------

// File: rtl/cypher_stream_sequencer.sv
//------------------------------------------------------------------------------
// cypher_stream_sequencer
//
// Purpose:
//   Sequences a 4-digit cypher match over a handshaked stream of 4-bit digits
//   and counts complete cypher occurrences. The cypher is latched when a run
//   starts; each accepted digit either advances the digit index, completes a
//   match, or restarts the index (single-level restart: a mismatching digit
//   that equals digit0 resumes at index 1, otherwise at index 0). A run ends
//   on a stop request or after MAX_DIGITS accepted digits, and the result is
//   held in DONE until the next start.
//
// Parameters:
//   SUM_W       width of the saturating match counter `sum`
//   MAX_DIGITS  digits accepted per run before automatic DONE (1..65535)
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   fullcypher   16-bit cypher, digit0 = [15:12] ... digit3 = [3:0]
//   start        begin a run (honoured in IDLE or DONE)
//   stop         end a run (honoured in RUN)
//   digit_valid  digit_in carries a digit
//   digit_in     stream digit
//   digit_ready  block accepts a digit this cycle (state RUN)
//   busy         state RUN
//   match_pulse  one-cycle pulse per completed match
//   done         state DONE
//   sum          completed-match count of the current/last run
//
// Build option:
//   CYPHER_OVERLAP_EN  when defined, the last digit of a match may begin the
//                      next match (overlapping count); otherwise the index
//                      returns to 0 after every match.
//------------------------------------------------------------------------------
module cypher_stream_sequencer #(
   parameter int SUM_W      = 10,
   parameter int MAX_DIGITS = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      fullcypher,
   input  logic             start,
   input  logic             stop,
   input  logic             digit_valid,
   input  logic [3:0]       digit_in,
   output logic             digit_ready,
   output logic             busy,
   output logic             match_pulse,
   output logic             done,
   output logic [SUM_W-1:0] sum
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [SUM_W-1:0] SUM_MAX  = {SUM_W{1'b1}};
   localparam logic [15:0]      CNT_LAST = 16'(MAX_DIGITS);

   state_t           state_r;
   logic [1:0]       idx_r;
   logic [15:0]      cnt_r;
   logic [15:0]      cypher_r;
   logic [SUM_W-1:0] sum_r;
   logic             match_pulse_r;

   logic             accept_s;
   logic             digit_hit_s;
   logic             restart_s;
   logic             full_match_s;
   logic [1:0]       idx_next_s;
   logic [15:0]      cnt_next_s;
   logic [SUM_W-1:0] sum_next_s;

   // Select digit i of a cypher; digit0 is the most significant nibble.
   function automatic logic [3:0] digit_at(input logic [15:0] cy, input logic [1:0] i);
      logic [3:0] d;
      case (i)
         2'd0:    d = cy[15:12];
         2'd1:    d = cy[11:8];
         2'd2:    d = cy[7:4];
         2'd3:    d = cy[3:0];
         default: d = 4'd0;
      endcase
      return d;
   endfunction

   // Handshake and per-digit match decode for the digit presented this cycle.
   always_comb begin
      accept_s     = digit_valid && (state_r == ST_RUN);
      digit_hit_s  = (digit_in == digit_at(cypher_r, idx_r));
      restart_s    = (digit_in == cypher_r[15:12]);
      full_match_s = accept_s && digit_hit_s && (idx_r == 2'd3);
      cnt_next_s   = cnt_r + 16'd1;
      if (sum_r == SUM_MAX) begin
         sum_next_s = sum_r;
      end else begin
         sum_next_s = sum_r + SUM_W'(1);
      end
   end

   // Next digit index: advance on a hit, restart from digit0 on a miss.
   always_comb begin
      idx_next_s = 2'd0;
      if (!digit_hit_s) begin
         // A mismatching digit may itself be the first digit of a new match.
         idx_next_s = restart_s ? 2'd1 : 2'd0;
      end else if (idx_r != 2'd3) begin
         idx_next_s = idx_r + 2'd1;
      end else begin
`ifdef CYPHER_OVERLAP_EN
         idx_next_s = restart_s ? 2'd1 : 2'd0;
`else
         idx_next_s = 2'd0;
`endif
      end
   end

   // Run/stop sequencing, digit index, digit count and match counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         idx_r         <= 2'd0;
         cnt_r         <= 16'd0;
         cypher_r      <= 16'd0;
         sum_r         <= '0;
         match_pulse_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               match_pulse_r <= 1'b0;
               if (start) begin
                  cypher_r <= fullcypher;
                  sum_r    <= '0;
                  idx_r    <= 2'd0;
                  cnt_r    <= 16'd0;
                  state_r  <= ST_RUN;
               end
            end
            ST_RUN: begin
               match_pulse_r <= full_match_s;
               if (accept_s) begin
                  idx_r <= idx_next_s;
                  cnt_r <= cnt_next_s;
                  if (full_match_s) begin
                     sum_r <= sum_next_s;
                  end
               end
               // A digit accepted alongside stop is fully processed above.
               if (stop || (accept_s && (cnt_next_s == CNT_LAST))) begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               idx_r         <= 2'd0;
               cnt_r         <= 16'd0;
               sum_r         <= '0;
               match_pulse_r <= 1'b0;
            end
         endcase
      end
   end

   assign digit_ready = (state_r == ST_RUN);
   assign busy        = (state_r == ST_RUN);
   assign done        = (state_r == ST_DONE);
   assign match_pulse = match_pulse_r;
   assign sum         = sum_r;

endmodule

// File: tb/tb_cypher_stream_sequencer.sv
//------------------------------------------------------------------------------
// Bench for cypher_stream_sequencer. Three instances share one stimulus:
//   inst 0: SUM_W=10, MAX_DIGITS=64
//   inst 1: SUM_W=10, MAX_DIGITS=8
//   inst 2: SUM_W=2,  MAX_DIGITS=64
// A reference model keeps each run's accepted digits and recounts matches by
// scanning that history; expected match sums are queued per instance and a
// negedge monitor pops them whenever a match pulse is due or seen.
//------------------------------------------------------------------------------
module tb_cypher_stream_sequencer;

`ifdef CYPHER_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] fullcypher;
   logic        start, stop, digit_valid;
   logic [3:0]  digit_in;

   logic [9:0]  d_sum [3];
   logic        d_rdy [3];
   logic        d_bsy [3];
   logic        d_mp  [3];
   logic        d_dn  [3];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int SW = (g == 2) ? 2 : 10;
      localparam int MD = (g == 1) ? 8 : 64;
      logic [SW-1:0] s;
      logic rdy, bsy, mp, dn;
      cypher_stream_sequencer #(.SUM_W(SW), .MAX_DIGITS(MD)) dut (
         .clock(clock), .reset(reset), .fullcypher(fullcypher),
         .start(start), .stop(stop), .digit_valid(digit_valid),
         .digit_in(digit_in), .digit_ready(rdy), .busy(bsy),
         .match_pulse(mp), .done(dn), .sum(s));
      assign d_sum[g] = 10'(s);
      assign d_rdy[g] = rdy;
      assign d_bsy[g] = bsy;
      assign d_mp[g]  = mp;
      assign d_dn[g]  = dn;
   end

   function automatic int smax_of(input int i);
      return (i == 2) ? 3 : 1023;
   endfunction

   function automatic int md_of(input int i);
      return (i == 1) ? 8 : 64;
   endfunction

   // Count matches in a digit history; returns count*2 + (last digit completed a match).
   function automatic int scan(input logic [3:0] h [64], input int n, input logic [15:0] cy);
      int p = 0;
      int c = 0;
      int last = 0;
      logic [3:0] want, first;
      first = cy[15:12];
      for (int k = 0; k < n; k++) begin
         want = 4'(cy >> (12 - 4 * p));
         last = 0;
         if (h[k] == want) begin
            if (p == 3) begin
               c++;
               last = 1;
               p = (OVL && h[k] == first) ? 1 : 0;
            end else begin
               p++;
            end
         end else begin
            p = (h[k] == first) ? 1 : 0;
         end
      end
      return c * 2 + last;
   endfunction

   // model state: 0 idle, 1 run, 2 done
   int          ms   [3];
   logic [15:0] mcy  [3];
   int          mlen [3];
   int          esum [3];
   logic [3:0]  hist [3][64];
   int          expq [3][$];

   // Reference model, evaluated on each rising edge from the inputs held there.
   initial begin
      int r, c;
      logic [3:0] h [64];
      for (int i = 0; i < 3; i++) begin
         ms[i] = 0; mlen[i] = 0; esum[i] = 0; mcy[i] = 16'h0;
      end
      forever begin
         @(posedge clock);
         for (int i = 0; i < 3; i++) begin
            if (!reset) begin
               ms[i] = 0; mlen[i] = 0; esum[i] = 0; mcy[i] = 16'h0;
            end else if (ms[i] != 1) begin
               if (start) begin
                  mcy[i] = fullcypher; mlen[i] = 0; esum[i] = 0; ms[i] = 1;
               end
            end else begin
               if (digit_valid) begin
                  hist[i][mlen[i]] = digit_in;
                  mlen[i]++;
                  h = hist[i];
                  r = scan(h, mlen[i], mcy[i]);
                  c = r / 2;
                  esum[i] = (c > smax_of(i)) ? smax_of(i) : c;
                  if (r % 2 == 1) expq[i].push_back(esum[i]);
                  if (mlen[i] == md_of(i)) ms[i] = 2;
               end
               if (stop) ms[i] = 2;
            end
         end
      end
   end

   // Monitor: compares status every falling edge and pops expected matches.
   initial begin
      int e;
      forever begin
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (d_bsy[i] !== (ms[i] == 1) || d_rdy[i] !== (ms[i] == 1) || d_dn[i] !== (ms[i] == 2)) begin
               errors++;
               $display("FAIL inst%0d status: busy/ready/done got %b%b%b expected state %0d",
                        i, d_bsy[i], d_rdy[i], d_dn[i], ms[i]);
            end
            checks++;
            if (d_sum[i] !== 10'(esum[i])) begin
               errors++;
               $display("FAIL inst%0d sum: got %0d expected %0d", i, d_sum[i], esum[i]);
            end
            if (expq[i].size() > 0 || d_mp[i] !== 1'b0) begin
               checks++;
               if (expq[i].size() == 0) begin
                  errors++;
                  $display("FAIL inst%0d match_pulse: got unexpected pulse, expected none", i);
               end else begin
                  e = expq[i].pop_front();
                  if (d_mp[i] !== 1'b1 || d_sum[i] !== 10'(e)) begin
                     errors++;
                     $display("FAIL inst%0d match: got pulse=%b sum=%0d expected pulse=1 sum=%0d",
                              i, d_mp[i], d_sum[i], e);
                  end
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic begin_run(input logic [15:0] c);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      fullcypher = c;
      start = 1'b1;
      tick();
      start = 1'b0;
      fullcypher = 16'($urandom);
   endtask

   task automatic send(input logic [3:0] d, input int gap);
      digit_valid = 1'b1;
      digit_in = d;
      tick();
      digit_valid = 1'b0;
      digit_in = 4'($urandom);
      repeat (gap) tick();
   endtask

   task automatic end_run();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      int pulses;
      logic [3:0] s2 [10];
      logic [3:0] s3 [7];
      s2 = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4};
      s3 = '{4'd1, 4'd2, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1};

      // reset holds off start and digits
      reset = 1'b0; start = 1'b1; stop = 1'b0; digit_valid = 1'b1;
      digit_in = 4'd1; fullcypher = 16'h1234;
      tick(); tick();
      check("reset_sum", int'(d_sum[0]), 0);
      check("reset_busy_ready_done", {d_bsy[0], d_rdy[0], d_dn[0]}, 0);
      reset = 1'b1; start = 1'b0; digit_valid = 1'b0;
      tick();
      check("idle_after_reset", int'(d_bsy[0]), 0);

      // single match, then stop holds the result
      begin_run(16'h1234);
      send(4'd1, 0); send(4'd2, 1); send(4'd3, 0); send(4'd4, 0);
      check("first_match_pulse", int'(d_mp[0]), 1);
      check("first_match_sum", int'(d_sum[0]), 1);
      tick();
      check("pulse_one_cycle", int'(d_mp[0]), 0);
      end_run();
      tick();
      check("stop_done", int'(d_dn[0]), 1);
      check("stop_sum_held", int'(d_sum[0]), 1);

      // restart rule recovers a repeated first digit
      begin_run(16'h1234);
      for (int k = 0; k < 10; k++) send(s2[k], 0);
      check("restart_sum", int'(d_sum[0]), 2);

      // overlap-dependent count
      begin_run(16'h1211);
      for (int k = 0; k < 7; k++) send(s3[k], 0);
      check("overlap_sum", int'(d_sum[0]), OVL ? 2 : 1);

      // digit limit on inst 1
      begin_run(16'h5555);
      for (int k = 0; k < 7; k++) send(4'd5, 1);
      check("limit_not_done_yet", int'(d_dn[1]), 0);
      send(4'd5, 0);
      check("limit_done", int'(d_dn[1]), 1);
      check("limit_sum", int'(d_sum[1]), 2);
      digit_valid = 1'b1; digit_in = 4'd5;
      #1;
      check("limit_ready_low", int'(d_rdy[1]), 0);
      tick();
      digit_valid = 1'b0;
      check("limit_sum_kept", int'(d_sum[1]), 2);
      begin_run(16'h5555);
      check("restart_clears_sum", int'(d_sum[1]), 0);
      check("restart_busy", int'(d_bsy[1]), 1);

      // saturation on inst 2
      begin_run(16'hAAAA);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         send(4'hA, 0);
         pulses += int'(d_mp[2]);
      end
      tick();
      check("sat_pulses", pulses, OVL ? 6 : 5);
      check("sat_sum", int'(d_sum[2]), 3);

      // reset mid-match leaves no partial progress
      begin_run(16'h1234);
      send(4'd1, 0); send(4'd2, 0); send(4'd3, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("midreset_busy", int'(d_bsy[0]), 0);
      begin_run(16'h1234);
      send(4'd4, 0);
      check("midreset_no_match", int'(d_mp[0]), 0);
      send(4'd1, 0); send(4'd2, 0); send(4'd3, 0); send(4'd4, 0);
      check("midreset_then_match", int'(d_sum[0]), 1);

      // randomized traffic checked by the model and monitor
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 399) != 0);
         start       = ($urandom_range(0, 19) == 0);
         stop        = ($urandom_range(0, 59) == 0);
         digit_valid = ($urandom_range(0, 2) != 0);
         digit_in    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
         fullcypher  = 16'($urandom) & 16'h3333;
         tick();
      end
      reset = 1'b1; start = 1'b0; stop = 1'b0; digit_valid = 1'b0;
      tick(); tick();
      check("queues_drained", expq[0].size() + expq[1].size() + expq[2].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
